// File: rtl/rr_mux_arbiter64.sv
// rr_mux_arbiter64
//   Round-robin arbiter sharing one WIDTH-bit 4:1 mux between four
//   requesters. The selected word is registered toward a single consumer
//   through a valid/ready output stage. An optional per-source lock lets the
//   last winner keep the bus for up to MAX_BURST consecutive grants.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req[3:0]   request per source (bit i = source i)
//   lock[3:0]  source i asks to keep priority for back-to-back grants
//   inZero..inThree  source data words
//   grant[3:0] combinational one-hot; source i's word is captured this edge
//   sel[1:0]   registered index of the source whose word is in out
//   out        registered selected word
//   out_valid  out holds an unconsumed word
//   out_ready  consumer accepts out this cycle
module rr_mux_arbiter64 #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  input  logic [WIDTH-1:0] inThree,
  input  logic [WIDTH-1:0] inTwo,
  input  logic [WIDTH-1:0] inOne,
  input  logic [WIDTH-1:0] inZero,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  typedef enum logic {IDLE, FULL} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       last;
  logic [3:0]       burst_cnt;
  logic             can_load;
  logic             arb;
  logic             sticky;
  logic             found;
  logic [1:0]       idx;
  logic [1:0]       win;
  logic [WIDTH-1:0] win_data;

  // reset_n gates arbitration so grant drops to zero as soon as reset asserts
  assign can_load = (state == IDLE) || out_ready;
  assign arb      = reset_n && can_load && (|req);
  assign sticky   = req[last] && lock[last] && (burst_cnt < MAXB);

  // Winner: sticky last winner first, otherwise first requester from ptr
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + i[1:0];
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    if (sticky) win = last;
  end

  always_comb begin
    case (win)
      2'd0:    win_data = inZero;
      2'd1:    win_data = inOne;
      2'd2:    win_data = inTwo;
      default: win_data = inThree;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (arb)                              state_nxt = FULL;
    else if (state == FULL && out_ready)  state_nxt = IDLE;
  end

  // Output decode
  always_comb begin
    out_valid = (state == FULL);
    grant     = '0;
    if (arb) grant[win] = 1'b1;
  end

  // Capture datapath and arbitration bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= '0;
      sel       <= '0;
      ptr       <= '0;
      last      <= '0;
      burst_cnt <= '0;
    end else if (arb) begin
      out  <= win_data;
      sel  <= win;
      ptr  <= win + 2'd1;
      last <= win;
      // A repeat win below the cap extends the burst; a new winner, or the
      // last winner re-selected by round-robin after hitting the cap, restarts at 1
      if (win == last && burst_cnt < MAXB) burst_cnt <= burst_cnt + 4'd1;
      else                                 burst_cnt <= 4'd1;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter64.sv
module tb_rr_mux_arbiter64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [63:0] inThree, inTwo, inOne, inZero;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [63:0] out;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  logic [63:0] dv [4];

  rr_mux_arbiter64 #(.WIDTH(64), .MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock),
    .inThree(inThree), .inTwo(inTwo), .inOne(inOne), .inZero(inZero),
    .grant(grant), .sel(sel), .out(out), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One capture cycle: check combinational grant, then the registered result
  task automatic cyc(input string tag, input logic [3:0] eg, input logic [1:0] es);
    #1;
    chk({tag, ".grant"}, 64'(grant), 64'(eg));
    tick();
    chk({tag, ".sel"}, 64'(sel), 64'(es));
    chk({tag, ".out"}, out, dv[es]);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic set_data();
    inZero = dv[0]; inOne = dv[1]; inTwo = dv[2]; inThree = dv[3];
  endtask

  initial begin
    reset_n = 1'b0; req = '0; lock = '0; out_ready = 1'b0;
    dv[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    dv[1] = 64'hD1D1_D1D1_D1D1_D1D1;
    dv[2] = 64'h0123_4567_89AB_CDEF;
    dv[3] = 64'hD3D3_D3D3_D3D3_D3D3;
    set_data();
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Load 0xAAAA.. into FULL, then reset mid-FULL
    req = 4'b0001; out_ready = 1'b1;
    cyc("pre_reset", 4'b0001, 2'd0);
    req = 4'b1111; out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst.out",   out, 64'd0);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.sel",   64'(sel), 64'd0);
    chk("rst.grant", 64'(grant), 64'd0);
    req = '0;
    tick();
    #2 reset_n = 1'b1;
    tick(); tick();
    chk("idle.out",   out, 64'd0);
    chk("idle.valid", 64'(out_valid), 64'd0);
    chk("idle.grant", 64'(grant), 64'd0);

    // Single request from source 2, one-cycle latency
    req = 4'b0100; out_ready = 1'b1;
    cyc("single", 4'b0100, 2'd2);

    // Drain back to IDLE (ptr=3 now)
    req = '0;
    #1 chk("drain1.grant", 64'(grant), 64'd0);
    tick();
    chk("drain1.valid", 64'(out_valid), 64'd0);
    chk("drain1.out",   out, dv[2]);

    // Round-robin with all requesting: ptr=3 so 3 first, then wrap
    dv[0] = 64'hD0D0_D0D0_D0D0_D0D0;
    dv[2] = 64'hD2D2_D2D2_D2D2_D2D2;
    set_data();
    req = 4'b1111;
    cyc("rr0", 4'b1000, 2'd3);
    cyc("rr1", 4'b0001, 2'd0);
    cyc("rr2", 4'b0010, 2'd1);
    cyc("rr3", 4'b0100, 2'd2);
    cyc("rr4", 4'b1000, 2'd3);
    cyc("rr5", 4'b0001, 2'd0);

    // Backpressure for 5 cycles: nothing moves
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp.grant", 64'(grant), 64'd0);
      tick();
      chk("bp.out",   out, dv[0]);
      chk("bp.sel",   64'(sel), 64'd0);
      chk("bp.valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    cyc("bp_release", 4'b0010, 2'd1);

    // Locked burst on source 1 (burst already at 1)
    lock = 4'b0010;
    cyc("lk1", 4'b0010, 2'd1);
    cyc("lk2", 4'b0010, 2'd1);
    cyc("lk3", 4'b0010, 2'd1);
    cyc("lk4", 4'b0100, 2'd2);
    cyc("lk5", 4'b1000, 2'd3);
    cyc("lk6", 4'b0001, 2'd0);
    cyc("lk7", 4'b0010, 2'd1);
    cyc("lk8", 4'b0010, 2'd1);
    // Sole requester at the cap still wins; burst restarts at 1
    req = 4'b0010;
    cyc("solo1", 4'b0010, 2'd1);
    cyc("solo2", 4'b0010, 2'd1);
    cyc("solo3", 4'b0010, 2'd1);
    req = 4'b1111;
    cyc("solo4", 4'b0010, 2'd1);
    cyc("solo5", 4'b0010, 2'd1);
    cyc("solo6", 4'b0010, 2'd1);
    cyc("solo7", 4'b0100, 2'd2);
    lock = '0;

    // Drain single word: out and sel kept
    req = '0;
    #1 chk("drain2.grant", 64'(grant), 64'd0);
    tick();
    chk("drain2.valid", 64'(out_valid), 64'd0);
    chk("drain2.out",   out, dv[2]);
    chk("drain2.sel",   64'(sel), 64'd2);
    out_ready = 1'b0;
    tick();
    chk("idle2.valid", 64'(out_valid), 64'd0);

    // IDLE loads regardless of out_ready (ptr=3, only source 0 asks)
    req = 4'b0001;
    cyc("idle_load", 4'b0001, 2'd0);
    // Simultaneous consume and load
    req = 4'b0100; out_ready = 1'b1;
    cyc("swap", 4'b0100, 2'd2);

    req = '0; out_ready = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
